// File: rtl/hub75_line_capture.sv
// HUB75 receive-side model: oversamples the panel pins, rebuilds each shifted row pair and
// commits it into a 2*ROWS_HALF x COLS frame store on every latch rise.
module hub75_line_capture #(
    parameter int COLS      = 64,
    parameter int ROWS_HALF = 16,
    parameter int SYNC      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hub_clk,
    input  logic        hub_lat,
    input  logic        hub_oe,
    input  logic [3:0]  hub_addr,
    input  logic [2:0]  hub_rgb0,
    input  logic [2:0]  hub_rgb1,
    input  logic [4:0]  rd_row,
    input  logic [5:0]  rd_col,
    output logic [2:0]  rd_rgb,
    output logic        line_valid,
    output logic [3:0]  line_addr,
    output logic [6:0]  line_len,
    output logic [15:0] line_on_time,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_overrun,
    output logic [1:0]  dbg_state
);

    localparam int          AW      = $clog2(ROWS_HALF);
    localparam int          SW      = COLS * 3;
    localparam int          LW      = $clog2(2 * SW);
    localparam logic [6:0]  COLS7   = 7'(COLS);
    localparam logic [6:0]  CNT_MAX = 7'd127;
    localparam logic [3:0]  LAST_A  = 4'(ROWS_HALF - 1);

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Pin bundle: {clk, lat, oe, addr[3:0], rgb0[2:0], rgb1[2:0]}; all pins share one chain
    // so data, address and OE stay aligned with the edges derived from the last stage.
    logic [12:0] sync_q [SYNC];
    logic [12:0] s;
    logic        clk_d, lat_d;
    logic        s_clk, s_lat, s_oe;
    logic [3:0]  s_addr;
    logic [2:0]  s_rgb0, s_rgb1;
    logic        shift_rise, lat_rise, shift_en, do_commit;

    logic [SW-1:0]    stg0, stg1;
    logic [6:0]       shift_cnt;
    logic [15:0]      oe_cnt;
    logic [3:0]       commit_addr;
    logic [2*SW-1:0]  mem [ROWS_HALF];
    logic [LW-1:0]    rd_base;

    assign s      = sync_q[SYNC-1];
    assign s_clk  = s[12];
    assign s_lat  = s[11];
    assign s_oe   = s[10];
    assign s_addr = s[9:6];
    assign s_rgb0 = s[5:3];
    assign s_rgb1 = s[2:0];

    assign shift_rise = s_clk & ~clk_d;
    assign lat_rise   = s_lat & ~lat_d;
    assign dbg_state  = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
            clk_d <= 1'b0;
            lat_d <= 1'b0;
        end else begin
            sync_q[0] <= {hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb0, hub_rgb1};
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            clk_d <= s_clk;
            lat_d <= s_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ALIGN;
        else      state_q <= state_d;
    end

    // A latch rise seen while COMMIT is in flight is dropped; COMMIT always lasts one cycle.
    always_comb begin
        state_d   = state_q;
        do_commit = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            ALIGN: begin
                if (lat_rise) state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = shift_rise;
                if (lat_rise) state_d = COMMIT;
            end
            COMMIT: begin
                shift_en  = shift_rise;
                do_commit = 1'b1;
                state_d   = SHIFT;
            end
            default: state_d = ALIGN;
        endcase
    end

    // Status outputs are single-cycle pulses with no back-pressure: line_valid, line_addr,
    // line_len, line_on_time, err_short and frame_done change together, on the same edge as the store write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stg0         <= '0;
            stg1         <= '0;
            shift_cnt    <= '0;
            oe_cnt       <= '0;
            commit_addr  <= '0;
            line_valid   <= 1'b0;
            line_addr    <= '0;
            line_len     <= '0;
            line_on_time <= '0;
            frame_done   <= 1'b0;
            err_short    <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (shift_en) begin
                stg0 <= {stg0[SW-4:0], s_rgb0};
                stg1 <= {stg1[SW-4:0], s_rgb1};
            end

            if (do_commit)
                shift_cnt <= shift_en ? 7'd1 : 7'd0;
            else if (shift_en && shift_cnt != CNT_MAX)
                shift_cnt <= shift_cnt + 7'd1;

            if (do_commit)
                oe_cnt <= s_oe ? 16'd0 : 16'd1;
            else if (!s_oe && oe_cnt != 16'hFFFF)
                oe_cnt <= oe_cnt + 16'd1;

            if (state_q == SHIFT && lat_rise) commit_addr <= s_addr;

            err_overrun <= shift_en && !do_commit && (shift_cnt == COLS7);
            line_valid  <= do_commit;
            err_short   <= do_commit && (shift_cnt < COLS7);
            frame_done  <= do_commit && (commit_addr == LAST_A);

            if (do_commit) begin
                line_addr    <= commit_addr;
                line_len     <= shift_cnt;
                line_on_time <= oe_cnt;
            end
        end
    end

    always_comb begin
        rd_base = LW'((32'(rd_row[AW]) * COLS + 32'(rd_col)) * 3);
    end

    // Lower half of each store word is the rgb0 (upper panel) line; rgb1 sits above it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < ROWS_HALF; r++) mem[r] <= '0;
            rd_rgb <= '0;
        end else begin
            if (do_commit) mem[commit_addr] <= {stg1, stg0};
            rd_rgb <= mem[rd_row[AW-1:0]][rd_base +: 3];
        end
    end

endmodule

// File: tb/tb_hub75_line_capture.sv
// Self-checking bench for hub75_line_capture: pin-level HUB75 driver, staging/store model
// and a commit scoreboard popped whenever the DUT reports a committed line.
module tb_hub75_line_capture;

  localparam int COLS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1;
  logic [3:0]  hub_addr = '0;
  logic [2:0]  hub_rgb0 = '0, hub_rgb1 = '0;
  logic [4:0]  rd_row = '0;
  logic [5:0]  rd_col = '0;
  logic [2:0]  rd_rgb;
  logic        line_valid, frame_done, err_short, err_overrun;
  logic [3:0]  line_addr;
  logic [6:0]  line_len;
  logic [15:0] line_on_time;
  logic [1:0]  dbg_state;

  hub75_line_capture dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
    .line_valid(line_valid), .line_addr(line_addr), .line_len(line_len),
    .line_on_time(line_on_time), .frame_done(frame_done), .err_short(err_short),
    .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: {chk_on, on_time[15:0], frame, short, len[6:0], addr[3:0]}
  logic [29:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [2:0]  m0 [COLS];
  logic [2:0]  m1 [COLS];
  logic [2:0]  mm [32][COLS];
  bit          aligned;
  bit          on_valid;
  int          cnt, oe_low_cnt, exp_ovr, ovr_at;
  int          n_valid = 0, n_ovr = 0, n_frame = 0;

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) begin
      m0[c] = '0; m1[c] = '0;
      for (int r = 0; r < 32; r++) mm[r][c] = '0;
    end
    aligned = 0; on_valid = 0; cnt = 0; oe_low_cnt = 0; exp_ovr = 0; ovr_at = -1;
    exp_q.delete();
  endtask

  // Advance one clk and watch the DUT's status pulses.
  task automatic tick();
    logic [29:0] e;
    if (hub_oe == 1'b0) oe_low_cnt++;
    @(negedge clk);
    if (err_overrun) begin n_ovr++; ovr_at = cnt; end
    if (frame_done) n_frame++;
    if (line_valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL line_valid_unexpected: got commit addr=%0d len=%0d, required none", line_addr, line_len);
      end else begin
        e = exp_q.pop_front();
        if (line_addr !== e[3:0] || line_len !== e[10:4] || err_short !== e[11] || frame_done !== e[12]) begin
          errors++;
          $display("FAIL commit_fields: got addr=%0d len=%0d short=%0b frame=%0b, required addr=%0d len=%0d short=%0b frame=%0b",
                   line_addr, line_len, err_short, frame_done, e[3:0], e[10:4], e[11], e[12]);
        end
        if (e[29]) begin
          checks++;
          if (line_on_time !== e[28:13]) begin
            errors++;
            $display("FAIL line_on_time: got %0d, required %0d", line_on_time, e[28:13]);
          end
        end
      end
    end
    if ((frame_done || err_short) && !line_valid) begin
      checks++; errors++;
      $display("FAIL stray_pulse: got frame_done=%0b err_short=%0b without line_valid, required 0", frame_done, err_short);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_shift(input logic [2:0] p0, input logic [2:0] p1);
    if (aligned) begin
      for (int c = COLS - 1; c > 0; c--) begin m0[c] = m0[c-1]; m1[c] = m1[c-1]; end
      m0[0] = p0; m1[0] = p1;
      cnt = (cnt < 127) ? cnt + 1 : 127;
      if (cnt == COLS + 1) exp_ovr++;
    end
  endtask

  task automatic shift_px(input logic [2:0] p0, input logic [2:0] p1);
    model_shift(p0, p1);
    hub_rgb0 = p0; hub_rgb1 = p1; hub_clk = 1'b1;
    ticks(2);
    hub_clk = 1'b0;
    ticks(2);
  endtask

  // Latch rise; with_shift raises hub_clk on the same cycle so the commit must include that pixel.
  task automatic latch(input logic [3:0] a, input bit with_shift, input logic [2:0] p0, input logic [2:0] p1);
    logic [29:0] e;
    if (with_shift) model_shift(p0, p1);
    if (!aligned) begin
      aligned = 1; cnt = 0;
    end else begin
      e = {on_valid, 16'(oe_low_cnt), (a == 4'd15), (cnt < COLS), 7'(cnt), a};
      exp_q.push_back(e);
      for (int c = 0; c < COLS; c++) begin
        mm[a][c] = m0[c]; mm[a + 16][c] = m1[c];
      end
      cnt = 0; oe_low_cnt = 0; on_valid = 1;
    end
    hub_addr = a; hub_lat = 1'b1;
    if (with_shift) begin hub_rgb0 = p0; hub_rgb1 = p1; hub_clk = 1'b1; end
    ticks(2);
    hub_lat = 1'b0; hub_clk = 1'b0;
    ticks(6);
  endtask

  task automatic read_px(input int row, input int col, output logic [2:0] v);
    rd_row = 5'(row); rd_col = 6'(col);
    tick();
    v = rd_rgb;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; hub_clk = 1'b0; hub_lat = 1'b0; hub_oe = 1'b1;
    ticks(n);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [2:0] v;
    model_clear();
    rst = 1'b0;
    ticks(3);
    checks++;
    if ({line_valid, line_addr, line_len, line_on_time, frame_done, err_short, err_overrun, rd_rgb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b addr=%0d len=%0d on=%0d frame=%0b short=%0b ovr=%0b rgb=%0d, required all 0",
               line_valid, line_addr, line_len, line_on_time, frame_done, err_short, err_overrun, rd_rgb);
    end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    rst = 1'b1;
    read_px(0, 0, v);
    checks++;
    if (v !== 3'b000) begin errors++; $display("FAIL reset_read_0_0: got %0d, required 0", v); end
    read_px(31, 63, v);
    checks++;
    if (v !== 3'b000) begin errors++; $display("FAIL reset_read_31_63: got %0d, required 0", v); end
  endtask

  task automatic test_align();
    logic [2:0] v, p;
    int v0;
    for (int i = 0; i < COLS; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    v0 = n_valid;
    latch(4'd7, 0, 3'd0, 3'd0);
    checks++;
    if (n_valid != v0) begin errors++; $display("FAIL align_no_commit: got %0d line_valid, required 0", n_valid - v0); end
    for (int i = 0; i < COLS; i++) begin
      p = 3'(COLS - 1 - i);
      shift_px(p, ~p);
    end
    latch(4'd5, 0, 3'd0, 3'd0);
    checks++;
    if (n_valid != v0 + 1) begin errors++; $display("FAIL align_commit_count: got %0d, required 1", n_valid - v0); end
    for (int c = 0; c < COLS; c++) begin
      p = 3'(c);
      read_px(5, c, v);
      checks++;
      if (v !== p) begin errors++; $display("FAIL align_read_row5 col=%0d: got %0d, required %0d", c, v, p); end
      read_px(21, c, v);
      checks++;
      if (v !== ~p) begin errors++; $display("FAIL align_read_row21 col=%0d: got %0d, required %0d", c, v, ~p); end
    end
  endtask

  task automatic test_short_line();
    logic [2:0] v;
    for (int i = 0; i < 10; i++) shift_px(3'b101, 3'($urandom_range(0, 7)));
    latch(4'd2, 0, 3'd0, 3'd0);
    for (int c = 0; c < COLS; c++) begin
      read_px(2, c, v);
      checks++;
      if (v !== mm[2][c] || (c < 10 && v !== 3'b101)) begin
        errors++; $display("FAIL short_read_row2 col=%0d: got %0d, required %0d", c, v, mm[2][c]);
      end
      read_px(18, c, v);
      checks++;
      if (v !== mm[18][c]) begin errors++; $display("FAIL short_read_row18 col=%0d: got %0d, required %0d", c, v, mm[18][c]); end
    end
  endtask

  task automatic test_overrun();
    logic [2:0] v;
    logic [2:0] pix [70];
    int o0;
    o0 = n_ovr;
    ovr_at = -1;
    for (int i = 0; i < 70; i++) begin
      pix[i] = 3'($urandom_range(0, 7));
      shift_px(pix[i], ~pix[i]);
    end
    latch(4'd9, 0, 3'd0, 3'd0);
    checks++;
    if (n_ovr - o0 != 1) begin errors++; $display("FAIL overrun_count: got %0d, required 1", n_ovr - o0); end
    checks++;
    if (ovr_at != COLS + 1) begin errors++; $display("FAIL overrun_position: got shift %0d, required %0d", ovr_at, COLS + 1); end
    read_px(9, 63, v);
    checks++;
    if (v !== pix[6]) begin errors++; $display("FAIL overrun_col63: got %0d, required %0d", v, pix[6]); end
    read_px(9, 0, v);
    checks++;
    if (v !== pix[69]) begin errors++; $display("FAIL overrun_col0: got %0d, required %0d", v, pix[69]); end
    for (int c = 0; c < COLS; c++) begin
      read_px(25, c, v);
      checks++;
      if (v !== mm[25][c]) begin errors++; $display("FAIL overrun_read_row25 col=%0d: got %0d, required %0d", c, v, mm[25][c]); end
    end
  endtask

  task automatic test_frame();
    logic [2:0] v;
    int v0, f0;
    v0 = n_valid; f0 = n_frame;
    for (int a = 0; a < 16; a++) begin
      hub_oe = 1'b0;
      ticks(200);
      hub_oe = 1'b1;
      for (int i = 0; i < COLS; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      latch(4'(a), 0, 3'd0, 3'd0);
    end
    checks++;
    if (n_valid - v0 != 16) begin errors++; $display("FAIL frame_line_count: got %0d, required 16", n_valid - v0); end
    checks++;
    if (n_frame - f0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d, required 1", n_frame - f0); end
    for (int c = 0; c < COLS; c += 7) begin
      read_px(31, c, v);
      checks++;
      if (v !== mm[31][c]) begin errors++; $display("FAIL frame_read_row31 col=%0d: got %0d, required %0d", c, v, mm[31][c]); end
    end
  endtask

  task automatic test_edge_cases();
    logic [2:0] v;
    int v0;
    for (int i = 0; i < COLS - 1; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    latch(4'd3, 1, 3'b110, 3'b011);
    read_px(3, 0, v);
    checks++;
    if (v !== 3'b110) begin errors++; $display("FAIL same_cycle_row3_col0: got %0d, required 6", v); end
    read_px(19, 0, v);
    checks++;
    if (v !== 3'b011) begin errors++; $display("FAIL same_cycle_row19_col0: got %0d, required 3", v); end
    read_px(3, 63, v);
    checks++;
    if (v !== mm[3][63]) begin errors++; $display("FAIL same_cycle_row3_col63: got %0d, required %0d", v, mm[3][63]); end

    for (int i = 0; i < 30; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    do_reset(2);
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d, required 0", dbg_state); end
    read_px(3, 0, v);
    checks++;
    if (v !== 3'b000) begin errors++; $display("FAIL midreset_row3: got %0d, required 0", v); end
    read_px(25, 10, v);
    checks++;
    if (v !== 3'b000) begin errors++; $display("FAIL midreset_row25: got %0d, required 0", v); end
    v0 = n_valid;
    for (int i = 0; i < COLS; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    latch(4'd11, 0, 3'd0, 3'd0);
    checks++;
    if (n_valid != v0) begin errors++; $display("FAIL midreset_align: got %0d line_valid, required 0", n_valid - v0); end
    for (int i = 0; i < COLS; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    latch(4'd4, 0, 3'd0, 3'd0);
    checks++;
    if (n_valid != v0 + 1) begin errors++; $display("FAIL midreset_commit: got %0d, required 1", n_valid - v0); end
    for (int c = 0; c < COLS; c += 9) begin
      read_px(20, c, v);
      checks++;
      if (v !== mm[20][c]) begin errors++; $display("FAIL midreset_read_row20 col=%0d: got %0d, required %0d", c, v, mm[20][c]); end
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_short_line();
    test_overrun();
    test_frame();
    test_edge_cases();
    ticks(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending commits, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
